// File: rtl/fft_twiddle_gen.sv
// Radix-2 DIT FFT address/twiddle sequencer: N_LOG2*N/2 beats per start, one register stage, valid/ready backpressure.
// Optional macro TWIDDLE_INV_EN adds an 'inverse' input that selects conjugate (IFFT) twiddles.
module fft_twiddle_gen #(
  parameter int N_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef TWIDDLE_INV_EN
  input  logic              inverse,
`endif
  input  logic              tw_ready,
  output logic              tw_valid,
  output logic [7:0]        tw_re,
  output logic [7:0]        tw_im,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [2:0]        stage,
  output logic              busy,
  output logic              done
);

  localparam int BW     = N_LOG2 - 1;
  localparam int N_HALF = 1 << (N_LOG2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        s_q, s_d;
  logic [BW-1:0]     b_q, b_d;
  logic              issued_q, issued_d;
  logic              valid_q, valid_d;
  logic [7:0]        re_q, re_d;
  logic [7:0]        im_q, im_d;
  logic [N_LOG2-1:0] addr_a_q, addr_a_d;
  logic [N_LOG2-1:0] addr_b_q, addr_b_d;
  logic [2:0]        stage_q, stage_d;
  logic              inv_w;

  // Quarter-wave cosine table, Q1.7; clipped at 127 so -128 never appears.
  function automatic logic [7:0] cos_rom(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:    v = 8'd127;
      5'd1:    v = 8'd127;
      5'd2:    v = 8'd126;
      5'd3:    v = 8'd122;
      5'd4:    v = 8'd118;
      5'd5:    v = 8'd113;
      5'd6:    v = 8'd106;
      5'd7:    v = 8'd99;
      5'd8:    v = 8'd91;
      5'd9:    v = 8'd81;
      5'd10:   v = 8'd71;
      5'd11:   v = 8'd60;
      5'd12:   v = 8'd49;
      5'd13:   v = 8'd37;
      5'd14:   v = 8'd25;
      5'd15:   v = 8'd13;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  logic [N_LOG2-1:0] b_ext, span_v, mask_v, pos_v, grp_v, a_v, bb_v;
  logic [5:0]        pos6, k_v, k64;
  logic [4:0]        ci, si;
  logic              cneg;
  logic [7:0]        cos_v, sin_v, twre_v, twim_v;
  logic              last_beat;

  always_comb begin
    b_ext  = {1'b0, b_q};
    span_v = N_LOG2'(1) << s_q;
    mask_v = span_v - N_LOG2'(1);
    pos_v  = b_ext & mask_v;
    grp_v  = b_ext >> s_q;
    a_v    = (grp_v << (s_q + 3'd1)) | pos_v;
    bb_v   = a_v + span_v;
    pos6   = 6'(pos_v);
    k_v    = pos6 << (3'(N_LOG2 - 1) - s_q);
    k64    = k_v << 3'(6 - N_LOG2);
    // Fold the half circle 0..31 onto the quarter table.
    if (k64 <= 6'd16) begin
      ci   = k64[4:0];
      si   = 5'(6'd16 - k64);
      cneg = 1'b0;
    end else begin
      ci   = 5'(6'd32 - k64);
      si   = 5'(k64 - 6'd16);
      cneg = 1'b1;
    end
    cos_v  = cneg ? (8'd0 - cos_rom(ci)) : cos_rom(ci);
    sin_v  = cos_rom(si);
    twre_v = cos_v;
    twim_v = inv_w ? sin_v : (8'd0 - sin_v);
  end

  assign last_beat = (s_q == 3'(N_LOG2 - 1)) && (b_q == BW'(N_HALF - 1));

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    b_d      = b_q;
    issued_d = issued_q;
    valid_d  = valid_q;
    re_d     = re_q;
    im_d     = im_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    stage_d  = stage_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          s_d      = 3'd0;
          b_d      = '0;
          issued_d = 1'b0;
        end
      end
      RUN: begin
        if (issued_q && valid_q && tw_ready) begin
          state_d = FIN;
          valid_d = 1'b0;
        end else if (!issued_q && (!valid_q || tw_ready)) begin
          valid_d  = 1'b1;
          re_d     = twre_v;
          im_d     = twim_v;
          addr_a_d = a_v;
          addr_b_d = bb_v;
          stage_d  = s_q;
          // Counters stop on the last beat; FIN is entered once it is taken.
          if (last_beat) begin
            issued_d = 1'b1;
          end else if (b_q == BW'(N_HALF - 1)) begin
            b_d = '0;
            s_d = s_q + 3'd1;
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= 3'd0;
      b_q      <= '0;
      issued_q <= 1'b0;
      valid_q  <= 1'b0;
      re_q     <= 8'd0;
      im_q     <= 8'd0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      stage_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      b_q      <= b_d;
      issued_q <= issued_d;
      valid_q  <= valid_d;
      re_q     <= re_d;
      im_q     <= im_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      stage_q  <= stage_d;
    end
  end

`ifdef TWIDDLE_INV_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      inv_q <= inverse;
    end
  end

  assign inv_w = inv_q;
`else
  assign inv_w = 1'b0;
`endif

  assign tw_valid = valid_q;
  assign tw_re    = re_q;
  assign tw_im    = im_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign stage    = stage_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == FIN);

endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Directed bench for fft_twiddle_gen (N_LOG2=4): streaming, stall, ignored restart, mid-run reset.
module tb_fft_twiddle_gen;

  localparam int NL    = 4;
  localparam int N     = 1 << NL;
  localparam int TOTAL = NL * N / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          inverse = 1'b0;
  logic          tw_ready = 1'b1;
  logic          tw_valid;
  logic [7:0]    tw_re, tw_im;
  logic [NL-1:0] addr_a, addr_b;
  logic [2:0]    stage;
  logic          busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fft_twiddle_gen #(.N_LOG2(NL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef TWIDDLE_INV_EN
    .inverse  (inverse),
`endif
    .tw_ready (tw_ready),
    .tw_valid (tw_valid),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .stage    (stage),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int rnd_q7(input real x);
    int r;
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else r = -$rtoi(-x + 0.5);
    if (r > 127) r = 127;
    if (r < -127) r = -127;
    return r;
  endfunction

  // Reference beat from the butterfly definition using real trig.
  task automatic model(input int idx, input bit inv,
                       output int s, output int a, output int bb, output int re, output int im);
    int b, span, grp, pos, k;
    real ang;
    s    = idx / (N / 2);
    b    = idx % (N / 2);
    span = 1 << s;
    grp  = b / span;
    pos  = b % span;
    a    = grp * 2 * span + pos;
    bb   = a + span;
    k    = pos * (N / (2 * span));
    ang  = 2.0 * 3.14159265358979 * k / N;
    re   = rnd_q7(128.0 * $cos(ang));
    im   = rnd_q7(128.0 * $sin(ang));
    if (!inv) im = -im;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, tw_valid, 0);
    chk({tag, "_re"}, tw_re, 0);
    chk({tag, "_im"}, tw_im, 0);
    chk({tag, "_a"}, addr_a, 0);
    chk({tag, "_b"}, addr_b, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run(input int stall_beat, input int stall_len,
                     input int restart_at, input int abort_at, input bit inv);
    int beat = 0, dones = 0, post = 0, stall_cnt = 0, snap = 0;
    bit finished = 0, aborted = 0;
    int es, ea, eb, ere, eim;
    @(negedge clk);
    start = 1'b1; tw_ready = 1'b1; inverse = inv;
    @(negedge clk);
    start = 1'b0; inverse = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_latency", tw_valid, 0);
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("done_after_last", beat, TOTAL);
        chk("valid_drop_at_done", tw_valid, 0);
        chk("busy_low_in_fin", busy, 0);
      end else if (dones > 0) begin
        post++;
        chk("idle_no_valid", tw_valid, 0);
        chk("idle_not_busy", busy, 0);
        if (post >= 3) finished = 1;
      end else begin
        chk("busy_in_run", busy, 1);
        chk("valid_streaming", tw_valid, 1);
        if (tw_valid && beat < TOTAL) begin
          model(beat, inv, es, ea, eb, ere, eim);
          chk("beat_stage", stage, es);
          chk("beat_addr_a", addr_a, ea);
          chk("beat_addr_b", addr_b, eb);
          chk("beat_re", $signed(tw_re), ere);
          chk("beat_im", $signed(tw_im), eim);
          if (beat == 0) begin
            chk("b0_a", addr_a, 0); chk("b0_b", addr_b, 1);
            chk("b0_re", $signed(tw_re), 127); chk("b0_im", $signed(tw_im), 0);
          end
          if (beat == 9) begin
            chk("s1b1_a", addr_a, 1); chk("s1b1_b", addr_b, 3);
            chk("s1b1_re", $signed(tw_re), 0); chk("s1b1_im", $signed(tw_im), inv ? 127 : -127);
          end
          if (beat == 29) begin
            chk("s3b5_stage", stage, 3); chk("s3b5_a", addr_a, 5); chk("s3b5_b", addr_b, 13);
            chk("s3b5_re", $signed(tw_re), -49); chk("s3b5_im", $signed(tw_im), inv ? 118 : -118);
          end
          if (beat == stall_beat && stall_cnt > 0)
            chk("stall_hold", {tw_re, tw_im, addr_a, addr_b, stage}, snap);
        end
        if (beat == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_zero("abort");
          aborted = 1;
          finished = 1;
        end
      end
      if (!finished) begin
        if (beat == stall_beat && stall_cnt < stall_len && tw_valid && !done) begin
          if (stall_cnt == 0) snap = {tw_re, tw_im, addr_a, addr_b, stage};
          tw_ready = 1'b0;
          stall_cnt++;
        end else begin
          tw_ready = 1'b1;
        end
        start = (beat == restart_at || beat == restart_at + 1) ? 1'b1 : 1'b0;
        if (tw_valid && tw_ready) beat++;
      end
    end
    start = 1'b0; tw_ready = 1'b1;
    if (aborted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_idle_valid", tw_valid, 0);
      end
      rst_n = 1'b1;
    end else begin
      chk("beat_count", beat, TOTAL);
      chk("done_pulses", dones, 1);
      if (stall_len > 0) chk("stall_cycles", stall_cnt, stall_len);
    end
  endtask

  initial begin
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_start", tw_valid, 0);
    end
    run(-1, 0, -1, -1, 1'b0);
    run(2, 3, -1, -1, 1'b0);
    run(-1, 0, 5, -1, 1'b0);
    run(-1, 0, -1, 10, 1'b0);
    run(-1, 0, -1, -1, 1'b0);
`ifdef TWIDDLE_INV_EN
    run(-1, 0, -1, -1, 1'b1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
